// File: rtl/effect_panel_plotter_if.sv
// Pixel-write port between the front-panel plotter (master) and the VGA adapter (slave).
interface effect_panel_plotter_if;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [11:0] colour;
   logic        writeEn;
   logic        plot_ready;

   modport master (output x, y, colour, writeEn, input plot_ready);
   modport slave  (input x, y, colour, writeEn, output plot_ready);
endinterface

// File: rtl/effect_panel_plotter.sv
// Amp front-panel overlay plotter: per-channel status boxes and 8-way dial needles.
// Optional macro SKIP_SAME_DIR_EN: dial jobs that would not change the needle emit no pixels.
module effect_panel_plotter #(
   parameter int          NUM_CH     = 3,
   parameter int          X0         = 26,
   parameter int          PITCH      = 47,
   parameter int          BOX_Y      = 21,
   parameter int          BOX_W      = 17,
   parameter int          BOX_H      = 7,
   parameter int          DIAL_XOFF  = 7,
   parameter int          DIAL_Y     = 52,
   parameter int          NEEDLE_LEN = 7,
   parameter logic [11:0] COL_ON     = 12'h2C3,
   parameter logic [11:0] COL_OFF    = 12'h222,
   parameter logic [11:0] COL_NEEDLE = 12'hC38,
   parameter logic [11:0] COL_BG     = 12'h000
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  clear_req,
   input  logic [NUM_CH-1:0]     box_req,
   input  logic [NUM_CH-1:0]     ch_on,
   input  logic [NUM_CH-1:0]     dial_req,
   input  logic [7*NUM_CH-1:0]   dial_data,
   output logic                  busy,
   effect_panel_plotter_if.master pix
);
   localparam int         CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [2:0] DIR_N = 3'd0;
`ifdef SKIP_SAME_DIR_EN
   localparam logic SKIP_EN = 1'b1;
`else
   localparam logic SKIP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_BOX      = 3'd1,
      S_ERASE    = 3'd2,
      S_DRAW     = 3'd3,
      S_CLR_NEXT = 3'd4
   } state_t;

   state_t              r_state, w_next;
   logic                r_pend_clr;
   logic [NUM_CH-1:0]   r_pend_box, r_pend_dial;
   logic [CHW-1:0]      r_ch;
   logic                r_clearing, r_skip;
   logic [2:0]          r_newdir;
   logic [2:0]          r_dir [NUM_CH];
   logic [7:0]          r_c, r_r;
   logic                r_all_issued;
   logic                r_we, r_busy;
   logic [7:0]          r_x;
   logic [6:0]          r_y;
   logic [11:0]         r_col;

   logic [CHW-1:0]      w_box_sel, w_dial_sel;
   logic                w_any_box, w_any_dial;
   logic [2:0]          w_qdir, w_ndir;
   logic                w_drawing, w_skip_now, w_accept, w_done, w_issue, w_last_idx, w_last_ch;
   logic                w_take_clr;
   logic [NUM_CH-1:0]   w_take_box, w_take_dial;
   int                  w_px_x, w_px_y;
   logic [11:0]         w_px_col;

   function automatic logic [2:0] quantise(input logic [6:0] v);
      logic [2:0] d;
      if      (v <= 7'd8)  d = 3'd0;
      else if (v <= 7'd18) d = 3'd1;
      else if (v <= 7'd30) d = 3'd2;
      else if (v <= 7'd42) d = 3'd3;
      else if (v <= 7'd54) d = 3'd4;
      else if (v <= 7'd66) d = 3'd5;
      else if (v <= 7'd78) d = 3'd6;
      else if (v <= 7'd91) d = 3'd7;
      else                 d = 3'd0;
      return d;
   endfunction

   // Encoding: 0 N, 1 NE, 2 E, 3 SE, 4 S, 5 SW, 6 W, 7 NW; screen y grows downwards.
   function automatic int dir_dx(input logic [2:0] d);
      case (d)
         3'd1, 3'd2, 3'd3: return 1;
         3'd5, 3'd6, 3'd7: return -1;
         default:          return 0;
      endcase
   endfunction

   function automatic int dir_dy(input logic [2:0] d);
      case (d)
         3'd0, 3'd1, 3'd7: return -1;
         3'd3, 3'd4, 3'd5: return 1;
         default:          return 0;
      endcase
   endfunction

   // Lowest-numbered pending box and dial channels.
   always_comb begin
      w_box_sel  = '0;
      w_dial_sel = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         w_box_sel  = r_pend_box[i]  ? CHW'(i) : w_box_sel;
         w_dial_sel = r_pend_dial[i] ? CHW'(i) : w_dial_sel;
      end
   end

   assign w_any_box   = |r_pend_box;
   assign w_any_dial  = |r_pend_dial;
   assign w_qdir      = quantise(dial_data[7*int'(w_dial_sel) +: 7]);
   assign w_take_clr  = (r_state == S_IDLE) && r_pend_clr;
   assign w_take_box  = ((r_state == S_IDLE) && !r_pend_clr && w_any_box) ?
                        (NUM_CH'(1) << w_box_sel) : '0;
   assign w_take_dial = ((r_state == S_IDLE) && !r_pend_clr && !w_any_box && w_any_dial) ?
                        (NUM_CH'(1) << w_dial_sel) : '0;

   assign w_drawing  = (r_state == S_BOX) || (r_state == S_ERASE) || (r_state == S_DRAW);
   assign w_skip_now = SKIP_EN && (r_state == S_ERASE) && r_skip && !r_clearing;
   assign w_accept   = r_we && pix.plot_ready;
   assign w_done     = w_accept && r_all_issued;
   assign w_issue    = w_drawing && !r_all_issued && !w_skip_now && (!r_we || pix.plot_ready);
   assign w_last_idx = (r_state == S_BOX) ?
                       ((r_c == 8'(BOX_W - 1)) && (r_r == 8'(BOX_H - 1))) :
                       (r_c == 8'(NEEDLE_LEN - 1));
   assign w_last_ch  = (r_ch == CHW'(NUM_CH - 1));

   // State register.
   always_ff @(posedge Clock) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic; a clear walks BOX -> ERASE -> DRAW -> CLR_NEXT for every channel.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (r_pend_clr || w_any_box) w_next = S_BOX;
            else if (w_any_dial)         w_next = S_ERASE;
            else                         w_next = S_IDLE;
         end
         S_BOX: begin
            if (w_done) w_next = r_clearing ? S_ERASE : S_IDLE;
            else        w_next = S_BOX;
         end
         S_ERASE: begin
            if (w_skip_now)  w_next = S_IDLE;
            else if (w_done) w_next = S_DRAW;
            else             w_next = S_ERASE;
         end
         S_DRAW: begin
            if (w_done) w_next = r_clearing ? S_CLR_NEXT : S_IDLE;
            else        w_next = S_DRAW;
         end
         S_CLR_NEXT: w_next = w_last_ch ? S_IDLE : S_BOX;
         default:    w_next = S_IDLE;
      endcase
   end

   // Pixel generator: coordinates and colour of the pixel at the current counters.
   always_comb begin
      w_ndir = (r_state == S_ERASE) ? r_dir[r_ch] : r_newdir;
      if (r_state == S_BOX) begin
         w_px_x   = X0 + int'(r_ch) * PITCH + int'(r_c);
         w_px_y   = BOX_Y + int'(r_r);
         w_px_col = ch_on[r_ch] ? COL_ON : COL_OFF;
      end else begin
         w_px_x   = X0 + int'(r_ch) * PITCH + DIAL_XOFF + dir_dx(w_ndir) * int'(r_c);
         w_px_y   = DIAL_Y + dir_dy(w_ndir) * int'(r_c);
         w_px_col = (r_state == S_ERASE) ? COL_BG : COL_NEEDLE;
      end
   end

   // Request bookkeeping, job setup, pixel counters and the registered pixel port.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_pend_clr   <= 1'b0;
         r_pend_box   <= '0;
         r_pend_dial  <= '0;
         r_ch         <= '0;
         r_clearing   <= 1'b0;
         r_skip       <= 1'b0;
         r_newdir     <= DIR_N;
         r_c          <= 8'd0;
         r_r          <= 8'd0;
         r_all_issued <= 1'b0;
         r_we         <= 1'b0;
         r_busy       <= 1'b0;
         r_x          <= 8'd0;
         r_y          <= 7'd0;
         r_col        <= 12'h000;
         for (int i = 0; i < NUM_CH; i++) r_dir[i] <= DIR_N;
      end else begin
         r_busy      <= (w_next != S_IDLE);
         r_pend_clr  <= (r_pend_clr & !w_take_clr) | clear_req;
         r_pend_box  <= (r_pend_box & ~w_take_box) | box_req;
         r_pend_dial <= (r_pend_dial & ~w_take_dial) | dial_req;

         if (r_state == S_IDLE) begin
            if (r_pend_clr) begin
               r_ch       <= '0;
               r_clearing <= 1'b1;
               r_newdir   <= DIR_N;
               r_skip     <= 1'b0;
            end else if (w_any_box) begin
               r_ch       <= w_box_sel;
               r_clearing <= 1'b0;
               r_skip     <= 1'b0;
            end else if (w_any_dial) begin
               r_ch       <= w_dial_sel;
               r_clearing <= 1'b0;
               r_newdir   <= w_qdir;
               r_skip     <= (w_qdir == r_dir[w_dial_sel]);
            end
         end else if (r_state == S_CLR_NEXT) begin
            if (w_last_ch) r_clearing <= 1'b0;
            else           r_ch       <= r_ch + CHW'(1);
         end

         // Counters index the next pixel to present; they restart on every state change.
         if ((w_next != r_state) || (r_state == S_CLR_NEXT)) begin
            r_c          <= 8'd0;
            r_r          <= 8'd0;
            r_all_issued <= 1'b0;
         end else if (w_issue) begin
            if ((r_state == S_BOX) && (r_c == 8'(BOX_W - 1))) begin
               r_c <= 8'd0;
               r_r <= r_r + 8'd1;
            end else begin
               r_c <= r_c + 8'd1;
            end
            r_all_issued <= w_last_idx;
         end

         if (w_issue) begin
            r_we  <= 1'b1;
            r_x   <= 8'(w_px_x);
            r_y   <= 7'(w_px_y);
            r_col <= w_px_col;
         end else if (w_accept) begin
            r_we <= 1'b0;
         end

         if ((r_state == S_DRAW) && w_done) r_dir[r_ch] <= r_newdir;
      end
   end

   assign pix.x       = r_x;
   assign pix.y       = r_y;
   assign pix.colour  = r_col;
   assign pix.writeEn = r_we;
   assign busy        = r_busy;
endmodule

// File: tb/tb_effect_panel_plotter.sv
// Directed, table-driven bench for effect_panel_plotter with an accepted-pixel scoreboard.
module tb_effect_panel_plotter;
   typedef struct packed { logic [7:0] x; logic [6:0] y; logic [11:0] c; } px_t;
   typedef struct { int val; int dx; int dy; } dial_vec_t;

   localparam logic [11:0] ON = 12'h2C3, OFF = 12'h222, NDL = 12'hC38, BG = 12'h000;

   logic        Clock = 1'b0;
   logic        Reset, clear_req, busy;
   logic [2:0]  box_req, ch_on, dial_req;
   logic [20:0] dial_data;

   effect_panel_plotter_if pif();

   effect_panel_plotter dut (
      .Clock(Clock), .Reset(Reset), .clear_req(clear_req), .box_req(box_req),
      .ch_on(ch_on), .dial_req(dial_req), .dial_data(dial_data), .busy(busy), .pix(pif)
   );

   always #5 Clock = ~Clock;

   px_t       cap[$];
   px_t       expq[$];
   px_t       mon_p;
   dial_vec_t tv[18];
   int        n_cmp = 0, n_fail = 0;
   int        cyc = 0, last_acc = -1, fall_cyc = -1;
   logic      prev_busy = 1'b0;

   // Monitor: records every pixel that the adapter accepts and the cycle busy falls.
   always begin
      @(negedge Clock);
      #1;
      cyc++;
      if (pif.writeEn === 1'b1 && pif.plot_ready === 1'b1) begin
         mon_p.x = pif.x; mon_p.y = pif.y; mon_p.c = pif.colour;
         cap.push_back(mon_p);
         last_acc = cyc;
      end
      if (prev_busy === 1'b1 && busy === 1'b0) fall_cyc = cyc;
      prev_busy = busy;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "time limit");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic px_t mkpx(input int x, input int y, input logic [11:0] c);
      px_t p;
      p.x = 8'(x); p.y = 7'(y); p.c = c;
      return p;
   endfunction

   task automatic exp_box(input int ch, input logic [11:0] c);
      for (int r = 0; r < 7; r++)
         for (int col = 0; col < 17; col++)
            expq.push_back(mkpx(26 + 47*ch + col, 21 + r, c));
   endtask

   task automatic exp_needle(input int ch, input int dx, input int dy, input logic [11:0] c);
      for (int k = 0; k < 7; k++)
         expq.push_back(mkpx(26 + 47*ch + 7 + dx*k, 52 + dy*k, c));
   endtask

   task automatic cmp_seq(input string name);
      int bad;
      bad = -1;
      check({name, " count"}, cap.size(), expq.size());
      for (int i = 0; i < cap.size() && i < expq.size(); i++)
         if (bad < 0 && cap[i] !== expq[i]) bad = i;
      if (bad >= 0)
         $display("  %s detail: idx %0d got (%0d,%0d,%h) expected (%0d,%0d,%h)", name, bad,
                  cap[bad].x, cap[bad].y, cap[bad].c, expq[bad].x, expq[bad].y, expq[bad].c);
      check({name, " first bad idx"}, bad, -1);
   endtask

   task automatic wait_quiet(input string name);
      int idle;
      idle = 0;
      for (int i = 0; i < 6000 && idle < 4; i++) begin
         @(negedge Clock);
         #2;
         if (busy === 1'b0) idle++;
         else               idle = 0;
      end
      check({name, " finished"}, (idle >= 4), 1'b1);
   endtask

   task automatic pulse_box(input logic [2:0] m);
      @(negedge Clock); box_req = m;
      @(negedge Clock); box_req = 3'b000;
   endtask

   task automatic dial(input int ch, input int val);
      @(negedge Clock);
      dial_data[7*ch +: 7] = 7'(val);
      dial_req = 3'(1 << ch);
      @(negedge Clock); dial_req = 3'b000;
   endtask

   task automatic do_reset();
      @(negedge Clock); Reset = 1'b1;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
   endtask

   initial begin
      px_t  f, l;
      logic [27:0] held;
      int   pdx, pdy, n;

      tv[0]  = '{25, 1, 0};   tv[1]  = '{91, -1, -1}; tv[2]  = '{8, 0, -1};
      tv[3]  = '{9, 1, -1};   tv[4]  = '{19, 1, 0};   tv[5]  = '{18, 1, -1};
      tv[6]  = '{31, 1, 1};   tv[7]  = '{30, 1, 0};   tv[8]  = '{43, 0, 1};
      tv[9]  = '{42, 1, 1};   tv[10] = '{55, -1, 1};  tv[11] = '{54, 0, 1};
      tv[12] = '{67, -1, 0};  tv[13] = '{66, -1, 1};  tv[14] = '{79, -1, -1};
      tv[15] = '{78, -1, 0};  tv[16] = '{127, 0, -1}; tv[17] = '{91, -1, -1};

      Reset = 1'b1; clear_req = 1'b0; box_req = 3'b000; ch_on = 3'b000;
      dial_req = 3'b000; dial_data = 21'd0; pif.plot_ready = 1'b1;
      repeat (3) @(negedge Clock);
      #2;
      check("reset x", pif.x, 8'd0);
      check("reset y", pif.y, 7'd0);
      check("reset colour", pif.colour, 12'h000);
      check("reset writeEn", pif.writeEn, 1'b0);
      check("reset busy", busy, 1'b0);
      @(negedge Clock); Reset = 1'b0;

      // Box on channel 1, switched on.
      cap.delete(); expq.delete(); ch_on = 3'b010;
      pulse_box(3'b010);
      wait_quiet("box1");
      exp_box(1, ON);
      cmp_seq("box1");
      f = (cap.size() > 0) ? cap[0] : '0;
      l = (cap.size() > 0) ? cap[cap.size()-1] : '0;
      check("box1 first x", f.x, 8'd73);
      check("box1 first y", f.y, 7'd21);
      check("box1 last x", l.x, 8'd89);
      check("box1 last y", l.y, 7'd27);
      check("box1 busy fall", fall_cyc, last_acc + 1);

      // Box on channel 2, switched off.
      cap.delete(); expq.delete();
      pulse_box(3'b100);
      wait_quiet("box2off");
      exp_box(2, OFF);
      cmp_seq("box2off");

      // Backpressure during a box job on channel 0.
      cap.delete(); expq.delete();
      pulse_box(3'b001);
      repeat (10) @(negedge Clock);
      pif.plot_ready = 1'b0;
      #2;
      held = {pif.writeEn, pif.x, pif.y, pif.colour};
      check("bp writeEn", pif.writeEn, 1'b1);
      for (int i = 0; i < 2; i++) begin
         @(negedge Clock);
         #2;
         check("bp hold", {pif.writeEn, pif.x, pif.y, pif.colour}, held);
      end
      @(negedge Clock); pif.plot_ready = 1'b1;
      wait_quiet("bp");
      exp_box(0, OFF);
      cmp_seq("bp");

      // Dial quantisation table on channel 0, starting from a fresh reset (needle at N).
      do_reset();
      pdx = 0; pdy = -1;
      for (int t = 0; t < 18; t++) begin
         cap.delete(); expq.delete();
         dial(0, tv[t].val);
         wait_quiet("dial");
         exp_needle(0, pdx, pdy, BG);
         exp_needle(0, tv[t].dx, tv[t].dy, NDL);
         cmp_seq($sformatf("dial %0d", tv[t].val));
         pdx = tv[t].dx; pdy = tv[t].dy;
      end

      // Simultaneous box2 + dial0, then a clear while box 2 is drawing.
      cap.delete(); expq.delete();
      ch_on = 3'b101; dial_data[6:0] = 7'd45;
      @(negedge Clock); box_req = 3'b100; dial_req = 3'b001;
      @(negedge Clock); box_req = 3'b000; dial_req = 3'b000;
      repeat (20) @(negedge Clock);
      clear_req = 1'b1;
      @(negedge Clock); clear_req = 1'b0;
      wait_quiet("simul");
      exp_box(2, ON);
      for (int ch = 0; ch < 3; ch++) begin
         exp_box(ch, (ch == 1) ? OFF : ON);
         if (ch == 0) exp_needle(0, pdx, pdy, BG);
         else         exp_needle(ch, 0, -1, BG);
         exp_needle(ch, 0, -1, NDL);
      end
      exp_needle(0, 0, -1, BG);
      exp_needle(0, 0, 1, NDL);
      cmp_seq("simul");

      // Reset in the middle of a box job; channel 0 needle was left at S.
      cap.delete(); expq.delete();
      pulse_box(3'b010);
      for (int i = 0; i < 500 && cap.size() < 50; i++) begin
         @(negedge Clock);
         #2;
      end
      check("rst reached 50", (cap.size() >= 50), 1'b1);
      @(negedge Clock); Reset = 1'b1;
      @(negedge Clock);
      #2;
      check("rst writeEn", pif.writeEn, 1'b0);
      check("rst busy", busy, 1'b0);
      Reset = 1'b0;
      n = cap.size();
      repeat (20) @(negedge Clock);
      #2;
      check("rst no pixels", cap.size(), n);
      cap.delete(); expq.delete();
      dial(0, 25);
      wait_quiet("rst dial");
      exp_needle(0, 0, -1, BG);
      exp_needle(0, 1, 0, NDL);
      cmp_seq("rst dial");

      // Repeated identical direction on channel 1.
      cap.delete(); expq.delete();
      dial(1, 20);
      wait_quiet("rep1");
      exp_needle(1, 0, -1, BG);
      exp_needle(1, 1, 0, NDL);
      cmp_seq("rep1");
      cap.delete(); expq.delete();
      dial(1, 20);
      wait_quiet("rep2");
`ifndef SKIP_SAME_DIR_EN
      exp_needle(1, 1, 0, BG);
      exp_needle(1, 1, 0, NDL);
`endif
      cmp_seq("rep2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/effect_panel_plotter.md
Name: effect_panel_plotter

Overview:
- Parametrised VGA overlay plotter for the amp front panel, driving the pixel-write port of the VGA adapter.
- Each of NUM_CH effect channels has a status box, filled with an on or off colour, and a dial needle that points in one of 8 directions.
- Requests are queued per channel and serviced one at a time.
- The plotter has a ready/valid pixel handshake and erases the previous needle before drawing the new one.

Parameters:
- NUM_CH, 3, number of effect channels.
- X0, 26, left x of the channel 0 box.
- PITCH, 47, x spacing between channels.
- BOX_Y, 21, top y of every box.
- BOX_W, 17, box width in pixels.
- BOX_H, 7, box height in pixels.
- DIAL_XOFF, 7, needle centre x offset from the box left edge.
- DIAL_Y, 52, needle centre y.
- NEEDLE_LEN, 7, needle pixels, including the centre pixel.
- COL_ON, 12'h2C3, box colour when the channel is on.
- COL_OFF, 12'h222, box colour when the channel is off.
- COL_NEEDLE, 12'hC38, needle colour.
- COL_BG, 12'h000, colour used to erase a needle.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- clear_req  in  1  pulse: redraw all boxes and reset all needles to N.
- box_req  in  NUM_CH  per-channel pulse: redraw that channel's box.
- ch_on  in  NUM_CH  per-channel on/off level; sampled per pixel while that box is drawn.
- dial_req  in  NUM_CH  per-channel pulse: redraw that channel's needle.
- dial_data  in  7*NUM_CH  packed 0..127 dial values; channel i is bits [7i+6:7i].
- plot_ready  in  1  adapter accepts the presented pixel this cycle.
- x  out  8  pixel x.
- y  out  7  pixel y.
- colour  out  12  pixel colour.
- writeEn  out  1  pixel valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: Reset is synchronous, active-high; clock is Clock.
  - On Reset: x=0, y=0, colour=0, writeEn=0, busy=0.
  - All pending bits are cleared and every stored direction is set to N.
  - Reset mid-operation aborts the current drawing; writeEn is 0 on the next cycle.
- Pending requests:
  - A request pulse sets its pending bit, OR-ed with any existing value.
  - A request arriving while busy is retained.
  - A request for the channel currently being drawn re-sets its bit, so that channel is serviced again later.
- Arbitration (in IDLE), priority order:
  1. clear.
  2. box, lowest channel first.
  3. dial, lowest channel first.
  - The pending bit is cleared when its job starts.
  - IDLE to job start takes 1 cycle; the first pixel appears on the cycle after that.
- Pixel handshake:
  - x, y and colour are valid while writeEn=1 and are held stable until plot_ready=1 in the same cycle.
  - The next pixel is presented on the following cycle.
  - Counters advance only on an accepted pixel.
  - writeEn must not drop while a pixel is unaccepted.
  - writeEn=0 in IDLE.
- FSM states: IDLE, BOX, ERASE, DRAW, CLR_NEXT.
  - BOX: raster order, row-major.
    - Pixel (c,r) maps to x = X0 + ch*PITCH + c, y = BOX_Y + r, for c in 0..BOX_W-1 and r in 0..BOX_H-1.
    - Colour is COL_ON if ch_on[ch], else COL_OFF.
    - After the last pixel is accepted, go to IDLE, or to CLR_NEXT during a clear.
  - ERASE: NEEDLE_LEN pixels at the stored direction, in COL_BG, then go to DRAW.
  - DRAW:
    - The new direction is quantised from dial_data, sampled once at job start.
    - Draws NEEDLE_LEN pixels in COL_NEEDLE, then stores the new direction and goes to IDLE.
  - Needle pixel k (k = 0..NEEDLE_LEN-1):
    - x = cx + dx*k, y = DIAL_Y + dy*k.
    - cx = X0 + ch*PITCH + DIAL_XOFF.
  - Direction table (dx,dy):
    - N (0,-1), NE (1,-1), E (1,0), SE (1,1).
    - S (0,1), SW (-1,1), W (-1,0), NW (-1,-1).
  - Quantisation of dial_data:
    - 0..8 and 92..127 map to N.
    - 9..18 NE; 19..30 E; 31..42 SE.
    - 43..54 S; 55..66 SW; 67..78 W; 79..91 NW.
  - Clear:
    - For ch = 0..NUM_CH-1: BOX, then ERASE at the stored direction, then DRAW with the direction forced to N.
    - CLR_NEXT increments ch, or returns to IDLE after the last channel.
    - box_req and dial_req bits pending during a clear survive and are serviced after it.
- Arithmetic:
  - Coordinates are computed at 9 bits signed and truncated to x[7:0] and y[6:0].
  - No clipping is performed; the integrator guarantees on-screen geometry.
- busy deasserts on the cycle after the final pixel of a job is accepted, with no pending work left.

Optional Feature:
- Macro: SKIP_SAME_DIR_EN.
- When defined: a dial job whose quantised direction equals the stored direction emits no pixels and returns to IDLE after 1 cycle. Clear still always redraws.
- When undefined: every dial job performs a full ERASE and DRAW.

Test Plan:
- Box request: with defaults and plot_ready=1, pulse box_req=3'b010 with ch_on[1]=1.
  - Required: exactly 119 writes, first (73,21), last (89,27), all colour 2C3.
  - busy falls 1 cycle after the last accept.
- Dial request after reset: pulse dial_req[0] with dial_data ch0=25.
  - Required: 7 erase pixels (33,52)..(33,46) in colour 000.
  - Then 7 draw pixels (33,52)..(39,52) in C38.
  - Then dial_data=91 gives erase along E, then draw (33,52)..(27,46).
- Backpressure: during a box job, hold plot_ready=0 for 3 cycles.
  - Required: x, y, colour and writeEn=1 held stable throughout; total accepted count stays 119.
- Simultaneous requests: box_req[2] and dial_req[0] in the same cycle, plus clear_req pulsed while box 2 is drawing.
  - Required service order: box 2, then full clear of channels 0..2 with needles at N, then dial 0.
- Reset mid-box at pixel 50:
  - Required: writeEn=0 next cycle, busy=0, no pixels until a new request, stored directions = N.
- Repeated same direction: with SKIP_SAME_DIR_EN, two dial_req[1] pulses with pitch value 20.
  - Required: the second job emits 0 pixels.
  - Without the macro: the second job emits 14 pixels.
